// File: rtl/note_staff_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : note_staff_ctrl_pkg                                          |
// | Description : Shared types and constants for the scrolling note staff:     |
// |               FSM state encoding, staff geometry, glyph codes and the      |
// |               logical-to-physical tile address helper.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package note_staff_ctrl_pkg;

    // Scroll / clear sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLR_TOP = 2'd1,
        ST_CLR_BOT = 2'd2
    } staff_state_t;

    // Staff geometry
    localparam int STAFF_COLS = 64;
    localparam int STAFF_ROWS = 2;
    localparam int TILE_PX    = 8;
    localparam int COL_W      = 6;
    localparam int CODE_W     = 5;
    localparam int MAP_DEPTH  = STAFF_COLS * STAFF_ROWS;
    localparam int MAP_AW     = 7;

    // Glyph codes
    localparam logic [CODE_W-1:0] BLANK     = 5'h00;
    localparam logic [CODE_W-1:0] QUARTER   = 5'h01;
    localparam logic [CODE_W-1:0] HALF      = 5'h02;
    localparam logic [CODE_W-1:0] WHOLE     = 5'h03;
    localparam logic [CODE_W-1:0] SHARP_TOP = 5'h18;
    localparam logic [CODE_W-1:0] SHARP_BOT = 5'h19;

    // Map address {row, physical column}; the 6-bit add wraps mod 64 so the
    // ring buffer needs no explicit modulo.
    function automatic logic [MAP_AW-1:0] tile_addr(input logic             row,
                                                     input logic [COL_W-1:0] lcol,
                                                     input logic [COL_W-1:0] head);
        logic [COL_W-1:0] pcol;
        pcol = lcol + head;
        return {row, pcol};
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_tile_map.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : note_tile_map                                                |
// | Description : 128 x 5-bit staff tile store. One synchronous write port,    |
// |               one registered read port whose output can be forced to 0.    |
// |   clk        in   clock                                                    |
// |   rst_n      in   synchronous active-low reset, clears every entry         |
// |   i_wr_en    in   write strobe                                             |
// |   i_wr_addr  in   {row, physical column}                                   |
// |   i_wr_data  in   glyph code to store                                      |
// |   i_rd_addr  in   {row, physical column} to read                           |
// |   i_rd_blank in   register code 0 instead of the stored entry              |
// |   o_rd_data  out  registered read data                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module note_tile_map
    import note_staff_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [MAP_AW-1:0] i_wr_addr,
    input  logic [CODE_W-1:0] i_wr_data,
    input  logic [MAP_AW-1:0] i_rd_addr,
    input  logic              i_rd_blank,
    output logic [CODE_W-1:0] o_rd_data
);

    logic [CODE_W-1:0] r_mem [0:MAP_DEPTH-1];
    logic [CODE_W-1:0] r_rd_data;

    // Whole map is flop-based so reset can clear it in a single cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MAP_DEPTH; i++) begin
                r_mem[i] <= BLANK;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read-during-write to the same entry returns the old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= BLANK;
        end else if (i_rd_blank) begin
            r_rd_data <= BLANK;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/note_staff_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : note_staff_ctrl                                              |
// | Description : Scrolling two-row note staff. Host writes glyph codes into   |
// |               a 64-column ring-buffer tile map; a scroll advances the ring |
// |               head at vertical blank and blanks the column scrolled out.   |
// |               A 2-stage pipeline turns DrawX/DrawY into a glyph pixel.     |
// |   Clk          in   clock                                                  |
// |   Reset_n      in   synchronous active-low reset                           |
// |   DrawX/DrawY  in   current VGA pixel column / row                         |
// |   frame_start  in   one-cycle pulse at start of vertical blank             |
// |   wr_en/wr_col/wr_row/wr_code  in  host tile write                         |
// |   wr_ready     out  host write accepted this cycle                         |
// |   scroll_req   in   request a one-column left scroll                       |
// |   scroll_busy  out  scroll pending or column clear in progress             |
// |   rom_addr     out  glyph ROM address {code, glyph row}                    |
// |   rom_data     in   glyph ROM row, bit 7 = leftmost pixel                  |
// |   pixel_on     out  lit pixel, 2 cycles after DrawX/DrawY                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module note_staff_ctrl
    import note_staff_ctrl_pkg::*;
#(
    parameter logic [9:0] STAFF_Y0 = 10'd200,
    parameter logic [9:0] STAFF_X0 = 10'd64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    input  logic        wr_en,
    input  logic [5:0]  wr_col,
    input  logic        wr_row,
    input  logic [4:0]  wr_code,
    output logic        wr_ready,
    input  logic        scroll_req,
    output logic        scroll_busy,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        pixel_on
);

    // ---------------------------------------------------------------- state
    staff_state_t      r_state;
    staff_state_t      w_state_nxt;
    logic [COL_W-1:0]  r_head;
    logic [COL_W-1:0]  w_head_nxt;
    logic [COL_W-1:0]  r_clr_col;
    logic [COL_W-1:0]  w_clr_col_nxt;
    logic              r_scroll_pend;
    logic              w_scroll_pend_nxt;

    // Tile map write port, shared by host writes and the clear sequence
    logic              w_map_wr_en;
    logic [MAP_AW-1:0] w_map_wr_addr;
    logic [CODE_W-1:0] w_map_wr_data;

    // Pixel pipeline
    logic              w_in_band;
    logic [COL_W-1:0]  w_band_col;
    logic              w_band_row;
    logic [MAP_AW-1:0] w_map_rd_addr;
    logic [CODE_W-1:0] w_code;
    logic [2:0]        r_xoff;
    logic [2:0]        r_yoff;
    logic              r_in_band;
    logic              r_pixel_on;

    // ------------------------------------------------------ band decode
    // Upper bounds compared at 11 bits so a band near the right/bottom edge
    // of the 10-bit coordinate space cannot wrap.
    assign w_in_band = (DrawX >= STAFF_X0) &&
                       ({1'b0, DrawX} < ({1'b0, STAFF_X0} + 11'd512)) &&
                       (DrawY >= STAFF_Y0) &&
                       ({1'b0, DrawY} < ({1'b0, STAFF_Y0} + 11'd16));

    assign w_band_col    = 6'((DrawX - STAFF_X0) >> 3);
    assign w_band_row    = 1'((DrawY - STAFF_Y0) >> 3);
    assign w_map_rd_addr = tile_addr(w_band_row, w_band_col, r_head);

    // --------------------------------------------------------- tile map
    // The map's registered read port is the stage-0 code register.
    note_tile_map u_tile_map (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .i_wr_en    (w_map_wr_en),
        .i_wr_addr  (w_map_wr_addr),
        .i_wr_data  (w_map_wr_data),
        .i_rd_addr  (w_map_rd_addr),
        .i_rd_blank (!w_in_band),
        .o_rd_data  (w_code)
    );

    // --------------------------------------------------- pixel pipeline
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_xoff     <= 3'd0;
            r_yoff     <= 3'd0;
            r_in_band  <= 1'b0;
            r_pixel_on <= 1'b0;
        end else begin
            r_xoff     <= DrawX[2:0];
            r_yoff     <= DrawY[2:0];
            r_in_band  <= w_in_band;
            r_pixel_on <= rom_data[3'd7 - r_xoff] & r_in_band;
        end
    end

    assign rom_addr = {w_code, r_yoff};
    assign pixel_on = r_pixel_on;

    // ------------------------------------------------ scroll sequencer
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= ST_IDLE;
            r_head        <= '0;
            r_clr_col     <= '0;
            r_scroll_pend <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_head        <= w_head_nxt;
            r_clr_col     <= w_clr_col_nxt;
            r_scroll_pend <= w_scroll_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_head_nxt        = r_head;
        w_clr_col_nxt     = r_clr_col;
        w_scroll_pend_nxt = r_scroll_pend | scroll_req;
        w_map_wr_en       = 1'b0;
        w_map_wr_addr     = tile_addr(wr_row, wr_col, r_head);
        w_map_wr_data     = wr_code;

        case (r_state)
            ST_IDLE: begin
                // Host write addresses through the pre-update head, even on
                // the cycle the scroll is taken.
                w_map_wr_en = wr_en;
                if (frame_start && r_scroll_pend) begin
                    w_state_nxt       = ST_CLR_TOP;
                    w_head_nxt        = r_head + 6'd1;
                    // Old head is the physical column that becomes logical 63.
                    w_clr_col_nxt     = r_head;
                    // A request arriving with the serviced pulse is kept for
                    // the next frame.
                    w_scroll_pend_nxt = scroll_req;
                end
            end
            ST_CLR_TOP: begin
                w_map_wr_en   = 1'b1;
                w_map_wr_addr = {1'b0, r_clr_col};
                w_map_wr_data = BLANK;
                w_state_nxt   = ST_CLR_BOT;
            end
            ST_CLR_BOT: begin
                w_map_wr_en   = 1'b1;
                w_map_wr_addr = {1'b1, r_clr_col};
                w_map_wr_data = BLANK;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wr_ready    = (r_state == ST_IDLE);
    assign scroll_busy = r_scroll_pend | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/note_staff_ctrl.md
NOTE_STAFF_CTRL -- requirements
Module: note_staff_ctrl

Interface
REQ-001 Parameter STAFF_Y0, default 10'd200, top pixel row of the 16-pixel staff band.
REQ-002 Parameter STAFF_X0, default 10'd64, left pixel column of the 512-pixel staff band.
REQ-003 Clk  in  1  single clock; all logic on its rising edge.
REQ-004 Reset_n  in  1  reset, synchronous, active-low.
REQ-005 DrawX  in  10  current VGA pixel column.
REQ-006 DrawY  in  10  current VGA pixel row.
REQ-007 frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-008 wr_en  in  1  host tile write request.
REQ-009 wr_col  in  6  logical staff column, 0..63.
REQ-010 wr_row  in  1  tile row: 0 = top glyph half, 1 = bottom half.
REQ-011 wr_code  in  5  glyph code, 0x00..0x1F.
REQ-012 wr_ready  out  1  high when a host write is accepted this cycle.
REQ-013 scroll_req  in  1  request one-column left scroll.
REQ-014 scroll_busy  out  1  scroll pending or clearing in progress.
REQ-015 rom_addr  out  8  glyph ROM address {code[4:0], glyph_row[2:0]}.
REQ-016 rom_data  in  8  glyph ROM row, combinational from rom_addr, bit 7 = leftmost pixel.
REQ-017 pixel_on  out  1  glyph pixel lit for the pixel presented 2 cycles earlier.

Function
REQ-018 Tile map SHALL hold 64 columns x 2 rows of 5-bit codes; physical column = (logical column + head) mod 64, head 6-bit.
REQ-019 Host write SHALL occur when wr_en and wr_ready are both high; wr_en with wr_ready low is ignored, not queued.
REQ-020 wr_ready SHALL be high only in state IDLE.
REQ-021 Stage 0: if STAFF_X0 <= DrawX < STAFF_X0+512 and STAFF_Y0 <= DrawY < STAFF_Y0+16, register code of tile (col = (DrawX-STAFF_X0)>>3, row = (DrawY-STAFF_Y0)>>3); outside the band, register code 0; also register DrawX[2:0], DrawY[2:0], in_band.
REQ-022 Stage 1: rom_addr SHALL be driven from stage-0 registers; register rom_data bit (7 - DrawX[2:0]) ANDed with in_band into pixel_on.
REQ-023 pixel_on latency SHALL be exactly 2 cycles from DrawX/DrawY.
REQ-024 scroll_req SHALL set scroll_pend; repeated requests before service coalesce into one scroll.
REQ-025 FSM states IDLE, CLR_TOP, CLR_BOT.
REQ-026 IDLE -> CLR_TOP on frame_start with scroll_pend: head <= head+1 (63 wraps to 0), clr_col <= old head, scroll_pend cleared.
REQ-027 CLR_TOP writes code 0 to (clr_col, row 0), -> CLR_BOT; CLR_BOT writes code 0 to (clr_col, row 1), -> IDLE.
REQ-028 scroll_req in the same cycle as a serviced frame_start SHALL set scroll_pend for the next frame.
REQ-029 Host write and FSM entry on the same cycle: host write completes using pre-update head.
REQ-030 scroll_busy = scroll_pend OR state != IDLE.
REQ-031 Pixel reads SHALL continue unaffected during CLR states.

Reset
REQ-032 On Reset_n low at a clock edge: state IDLE, head 0, scroll_pend 0, all tile codes 0, pipeline registers 0, pixel_on 0, rom_addr 0, scroll_busy 0, wr_ready 1 after release.
REQ-033 Reset mid-clear SHALL abandon the clear; entire map returns to 0.

Structure
REQ-034 Shared package SHALL hold FSM state enum, STAFF_COLS=64, TILE_PX=8, glyph code constants (BLANK=0x00, QUARTER=0x01, HALF=0x02, SHARP_TOP=0x18 ...).
REQ-035 Tile map SHALL be one sub-module note_tile_map (128x5, one write port, one registered read port).

Verification
REQ-036 Write col 0 row 0 code 0x01; scan DrawX=STAFF_X0..+7, DrawY=STAFF_Y0+3 -> pixel_on 11111111 two cycles later, rom_addr 0x0B.
REQ-037 Pixel at DrawX=STAFF_X0-1 with code present -> pixel_on 0; DrawY=STAFF_Y0+16 -> pixel_on 0.
REQ-038 Write col 1 code 0x02, scroll_req, frame_start -> glyph now at logical col 0; logical col 63 both rows read 0; wr_ready low exactly 2 cycles.
REQ-039 64 scrolls -> head returns to 0; scroll_req x3 before frame_start -> single scroll only.
REQ-040 wr_en during CLR_TOP -> write dropped, map unchanged; scroll_req with frame_start -> scroll_busy stays high, scroll next frame.
REQ-041 Reset_n low during CLR_BOT -> state IDLE, all tiles 0, pixel_on 0 next cycle.
